// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor (ALIGN, ADD, NORM, ROUND stages).
// Subnormals are flushed to zero; results round to nearest even.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [EXP_W+MAN_W:0]   Datain1,
    input  logic [EXP_W+MAN_W:0]   Datain2,
    input  logic                   Mode,
    input  logic                   Data_valid,
    output logic                   Data_ready,
    output logic [EXP_W+MAN_W:0]   Dataout,
    output logic                   Dataout_valid,
    input  logic                   Dataout_ready,
    output logic [2:0]             Exc,
    output logic                   Inexact
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;          // hidden bit + fraction + G/R/S
    localparam int EW  = EXP_W + 2;          // room for carry and negative exponents
    localparam int LZW = $clog2(SW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state_reg, state_next;

    logic [W-1:0]     a_reg, b_reg;
    logic [SW-1:0]    big_sig_reg, small_sig_reg;
    logic [EW-1:0]    exp_reg;
    logic             sign_reg, eff_sub_reg, zero_reg;
    logic             special_reg;
    logic [W-1:0]     special_val_reg;
    logic [2:0]       special_exc_reg;
    logic [SW:0]      sum_reg;
    logic [SW-1:0]    norm_reg;
    logic [W-1:0]     dout_reg;
    logic [2:0]       exc_reg;
    logic             inexact_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Data_valid) state_next = ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (Dataout_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand unpack, subnormal flush and magnitude ordering
    logic [EXP_W-1:0] ea, eb, e_big, e_small, exp_diff;
    logic [MAN_W-1:0] fa, fb, f_big, f_small;
    logic             sa, sb, s_big, a_ge;
    logic             a_nan, b_nan, a_inf, b_inf;
    logic [SW-1:0]    big_ext, small_ext, small_al, lost_bits;

    assign ea       = a_reg[W-2:MAN_W];
    assign eb       = b_reg[W-2:MAN_W];
    assign fa       = (ea == '0) ? '0 : a_reg[MAN_W-1:0];
    assign fb       = (eb == '0) ? '0 : b_reg[MAN_W-1:0];
    assign sa       = a_reg[W-1];
    assign sb       = b_reg[W-1];
    assign a_nan    = (ea == EXP_ONES) && (fa != '0);
    assign b_nan    = (eb == EXP_ONES) && (fb != '0);
    assign a_inf    = (ea == EXP_ONES) && (fa == '0);
    assign b_inf    = (eb == EXP_ONES) && (fb == '0);
    assign a_ge     = {ea, fa} >= {eb, fb};
    assign e_big    = a_ge ? ea : eb;
    assign e_small  = a_ge ? eb : ea;
    assign f_big    = a_ge ? fa : fb;
    assign f_small  = a_ge ? fb : fa;
    assign s_big    = a_ge ? sa : sb;
    assign big_ext  = {e_big != '0, f_big, 3'b000};
    assign small_ext = {e_small != '0, f_small, 3'b000};
    assign exp_diff = e_big - e_small;

    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_lost
            assign lost_bits[gi] = small_ext[gi] & (32'(exp_diff) > gi);
        end
    endgenerate

    always_comb begin
        if (32'(exp_diff) >= MAN_W + 3)
            small_al = {{(SW-1){1'b0}}, |small_ext};
        else
            small_al = (small_ext >> exp_diff) | {{(SW-1){1'b0}}, |lost_bits};
    end

    logic             sp_hit;
    logic [W-1:0]     sp_val;
    logic [2:0]       sp_exc;

    always_comb begin
        sp_hit = 1'b1;
        sp_val = '0;
        sp_exc = 3'b000;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sp_val = QNAN;
            sp_exc = 3'b100;
        end else if (a_inf) begin
            sp_val = a_reg;
        end else if (b_inf) begin
            sp_val = b_reg;
        end else begin
            sp_hit = 1'b0;
        end
    end

    // Significand add/subtract; big >= small is guaranteed by the ordering
    logic [SW:0] sum_next;
    assign sum_next = eff_sub_reg ? ({1'b0, big_sig_reg} - {1'b0, small_sig_reg})
                                  : ({1'b0, big_sig_reg} + {1'b0, small_sig_reg});

    // Normalisation with a single-cycle leading-zero count
    logic [LZW-1:0] lz;
    logic [SW-1:0]  norm_next;
    logic [EW-1:0]  exp_norm_next;

    always_comb begin
        lz = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (sum_reg[i]) lz = LZW'(SW - 1 - i);
    end

    always_comb begin
        if (sum_reg[SW]) begin
            norm_next     = {sum_reg[SW:2], sum_reg[1] | sum_reg[0]};
            exp_norm_next = exp_reg + EW'(1);
        end else begin
            norm_next     = sum_reg[SW-1:0] << lz;
            exp_norm_next = exp_reg - EW'(lz);
        end
    end

    // Round to nearest even and final result selection
    logic [MAN_W:0]   mant;
    logic             g_bit, r_bit, s_bit, grs, round_up, ovf, unf;
    logic [MAN_W+1:0] mant_rnd;
    logic [MAN_W-1:0] frac_fin;
    logic [EW-1:0]    exp_fin;
    logic [W-1:0]     dout_next;
    logic [2:0]       exc_next;
    logic             inexact_next;

    assign mant     = norm_reg[SW-1:3];
    assign g_bit    = norm_reg[2];
    assign r_bit    = norm_reg[1];
    assign s_bit    = norm_reg[0];
    assign grs      = g_bit | r_bit | s_bit;
    assign round_up = g_bit & (r_bit | s_bit | mant[0]);
    assign mant_rnd = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};

    always_comb begin
        if (mant_rnd[MAN_W+1]) begin
            frac_fin = mant_rnd[MAN_W:1];
            exp_fin  = exp_reg + EW'(1);
        end else begin
            frac_fin = mant_rnd[MAN_W-1:0];
            exp_fin  = exp_reg;
        end
    end

    assign ovf = !exp_fin[EW-1] && (exp_fin >= {2'b00, EXP_ONES});
    assign unf = exp_fin[EW-1] || (exp_fin == '0);

    always_comb begin
        dout_next    = {sign_reg, exp_fin[EXP_W-1:0], frac_fin};
        exc_next     = 3'b000;
        inexact_next = grs;
        if (special_reg) begin
            dout_next    = special_val_reg;
            exc_next     = special_exc_reg;
            inexact_next = 1'b0;
        end else if (zero_reg) begin
            dout_next    = {sign_reg, {(W-1){1'b0}}};
            inexact_next = 1'b0;
        end else if (ovf) begin
            dout_next    = {sign_reg, EXP_ONES, {MAN_W{1'b0}}};
            exc_next     = 3'b010;
            inexact_next = 1'b1;
        end else if (unf) begin
            dout_next    = '0;
            exc_next     = 3'b001;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_reg           <= '0;
            b_reg           <= '0;
            big_sig_reg     <= '0;
            small_sig_reg   <= '0;
            exp_reg         <= '0;
            sign_reg        <= 1'b0;
            eff_sub_reg     <= 1'b0;
            zero_reg        <= 1'b0;
            special_reg     <= 1'b0;
            special_val_reg <= '0;
            special_exc_reg <= 3'b000;
            sum_reg         <= '0;
            norm_reg        <= '0;
            dout_reg        <= '0;
            exc_reg         <= 3'b000;
            inexact_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (Data_valid) begin
                    a_reg <= Datain1;
                    b_reg <= {Datain2[W-1] ^ Mode, Datain2[W-2:0]};
                end
                ALIGN: begin
                    big_sig_reg     <= big_ext;
                    small_sig_reg   <= small_al;
                    exp_reg         <= {2'b00, e_big};
                    sign_reg        <= s_big;
                    eff_sub_reg     <= sa ^ sb;
                    special_reg     <= sp_hit;
                    special_val_reg <= sp_val;
                    special_exc_reg <= sp_exc;
                end
                ADD: begin
                    sum_reg <= sum_next;
                    // an exact cancellation is always +0
                    if (eff_sub_reg && (sum_next == '0)) sign_reg <= 1'b0;
                end
                NORM: begin
                    norm_reg <= norm_next;
                    exp_reg  <= exp_norm_next;
                    zero_reg <= (sum_reg == '0);
                end
                ROUND: begin
                    dout_reg    <= dout_next;
                    exc_reg     <= exc_next;
                    inexact_reg <= inexact_next;
                end
                default: ;
            endcase
        end
    end

    assign Data_ready    = (state_reg == IDLE);
    assign Dataout_valid = (state_reg == DONE);
    assign Dataout       = dout_reg;
    assign Exc           = exc_reg;
    assign Inexact       = inexact_reg;

endmodule
